seg_scan_ctrl: RTL

- Time-multiplexes N 4-bit digit values onto one shared seg_decoder instance and drives the common anode-enable lines of an N-digit 7-segment display.
- Holds a shadow digit buffer loaded through a pulse handshake. The buffer is applied only at frame boundaries so the display never shows a mix of old and new digits.
- Sits between the game/score logic and the seg_decoder. It compensates for the decoder's one-cycle registered latency.

---
 rtl/seg_scan_ctrl_pkg.sv | 24 ++
 rtl/seg_lzs_mask.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: glyph codes, FSM encodings, anode polarity helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package seg_scan_ctrl_pkg;

    // Extra glyphs the shared seg_decoder renders beyond the decimal digits.
    localparam logic [3:0] DIG_GLYPH_A = 4'hA;
    localparam logic [3:0] DIG_GLYPH_B = 4'hB;

    // Scan FSM encodings.
    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // Pin level that lights an anode for the given polarity.
    function automatic logic an_on(input logic act_low);
        return ~act_low;
    endfunction

    // Pin level that darkens an anode for the given polarity.
    function automatic logic an_off(input logic act_low);
        return act_low;
    endfunction

endpackage

// File: rtl/seg_lzs_mask.sv
// Per-digit dark mask from live blank bits plus optional leading-zero suppression.
// Latency: combinational.
// Backpressure: none. Ports: digits (packed 4-bit codes, digit 0 rightmost), blank_mask, dark (1 = keep digit off).
module seg_lzs_mask #(
    parameter int N_DIG = 4,
    parameter int LZS   = 1
) (
    input  logic [4*N_DIG-1:0] digits,
    input  logic [N_DIG-1:0]   blank_mask,
    output logic [N_DIG-1:0]   dark
);

    logic upper_zero;

    // Walk from the most significant digit down; upper_zero stays set while
    // every digit seen so far (including the current one) is zero. Digit 0 is
    // excluded so a zero value still shows a single "0".
    always_comb begin
        upper_zero = 1'b1;
        dark       = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (digits[4*i +: 4] == 4'h0);
            dark[i]    = blank_mask[i] || ((LZS != 0) && (i != 0) && upper_zero);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes N_DIG digit codes onto one external registered seg_decoder and drives the anode enables.
// Latency: anode follows the FSM by 1 cycle to line up with the decoder register; load_ack at the next frame boundary.
// Backpressure: none; load is a fire-and-forget pulse, later loads before the boundary overwrite earlier ones.
// Ports: clk, rst (async high), load/digits_in (shadow load), blank_mask (live), load_ack, dec_num (to decoder), an, frame_sync.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIG      = 4,
    parameter int DIV        = 50000,
    parameter int GUARD      = 16,
    parameter int AN_ACT_LOW = 1,
    parameter int LZS        = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [4*N_DIG-1:0] digits_in,
    input  logic [N_DIG-1:0]   blank_mask,
    output logic               load_ack,
    output logic [3:0]         dec_num,
    output logic [N_DIG-1:0]   an,
    output logic               frame_sync
);

    localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = $clog2(N_DIG);
    localparam logic ACT_LOW = (AN_ACT_LOW != 0);

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

    logic [0:0]         state;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      counter;
    logic [4*N_DIG-1:0] active;
    logic [4*N_DIG-1:0] pending;
    logic               pend_valid;

    logic [4*N_DIG-1:0] commit_src;
    logic [N_DIG-1:0]   dark;
    logic [N_DIG-1:0]   an_nxt;
    logic [3:0]         next_code;
    logic               guard_done;
    logic               show_done;
    logic               commit_pt;
    logic               do_commit;

    assign guard_done = (state == ST_GUARD) && (counter == GUARD_LAST);
    assign show_done  = (state == ST_SHOW)  && (counter == SHOW_LAST);

    // Frame boundary: end of digit 0's guard gap.
    assign commit_pt  = guard_done && (idx == '0);

    // A load landing on the boundary bypasses the pending buffer.
    assign commit_src = load ? digits_in : pending;
    assign do_commit  = commit_pt && (load || pend_valid);

    // On the boundary cycle the decoder must already see the newly committed
    // code for digit 0, not the stale one in the active buffer.
    assign next_code = do_commit ? commit_src[{idx, 2'b00} +: 4]
                                 : active[{idx, 2'b00} +: 4];

    seg_lzs_mask #(
        .N_DIG (N_DIG),
        .LZS   (LZS)
    ) u_lzs (
        .digits     (active),
        .blank_mask (blank_mask),
        .dark       (dark)
    );

    always_comb begin
        an_nxt = {N_DIG{an_off(ACT_LOW)}};
        if ((state == ST_SHOW) && !dark[idx]) begin
            an_nxt[idx] = an_on(ACT_LOW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_GUARD;
            idx        <= '0;
            counter    <= '0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            dec_num    <= 4'h0;
            an         <= {N_DIG{an_off(ACT_LOW)}};
            load_ack   <= 1'b0;
            frame_sync <= 1'b0;
        end else begin
            load_ack   <= do_commit;
            frame_sync <= commit_pt;
            // Registered one cycle behind the FSM so the anode switches on
            // together with the decoder's registered segment output, and
            // switches off before dec_num moves to the next digit.
            an         <= an_nxt;

            if (state == ST_GUARD) begin
                dec_num <= next_code;
            end

            if (guard_done) begin
                state   <= ST_SHOW;
                counter <= '0;
            end else if (show_done) begin
                state   <= ST_GUARD;
                counter <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                counter <= counter + 1'b1;
            end

            if (do_commit) begin
                active     <= commit_src;
                pend_valid <= 1'b0;
            end else if (load) begin
                pending    <= digits_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
